// File: rtl/jtframe_cen_pkg.sv
// jtframe_cen_pkg
// Shared definitions for the fractional clock-enable generator:
//   CEN_WC      default width of the n/m ratio operands
//   CREDIT_W    width of the stall credit counter
//   CREDIT_MAX  saturation value of the stall credit counter
//   ratio_valid true when a requested n/m ratio can be adopted (0 < n <= m)
package jtframe_cen_pkg;

    localparam int CEN_WC   = 10;
    localparam int CREDIT_W = 4;
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = 4'd15;

    // A ratio is usable when the denominator is non-zero and 0 < n <= m.
    function automatic logic ratio_valid(input logic [31:0] n, input logic [31:0] m);
        return (m != 32'd0) && (n != 32'd0) && (n <= m);
    endfunction

endpackage

// File: rtl/jtframe_frac_acc.sv
// jtframe_frac_acc
// Fractional accumulator: adds n_act every clk and wraps modulo m_act,
// flagging the wrap (cen0) and the half-period crossing (cenb0).
// Outputs are combinational from the current accumulator state; the parent
// registers them.
// Ports:
//   clk    system clock
//   rst    synchronous active-high reset
//   n_act  active numerator
//   m_act  active denominator
//   clr    restart the accumulator (ratio change)
//   cen0   raw wrap flag for this cycle
//   cenb0  raw half-period flag for this cycle
module jtframe_frac_acc
    import jtframe_cen_pkg::*;
#(
    parameter int WC = CEN_WC
)(
    input  logic          clk,
    input  logic          rst,
    input  logic [WC-1:0] n_act,
    input  logic [WC-1:0] m_act,
    input  logic          clr,
    output logic          cen0,
    output logic          cenb0
);

    logic [WC:0]   acc_r;
    logic          half_r;
    logic [WC+1:0] sum_s;
    logic [WC+1:0] m_ext_s;
    logic [WC+1:0] mh_ext_s;
    logic [WC:0]   acc_nxt_s;
    logic          half_nxt_s;

    // Sum, wrap compare and half-phase detection for the current cycle.
    always_comb begin
        sum_s    = {1'b0, acc_r} + {2'b00, n_act};
        m_ext_s  = {2'b00, m_act};
        mh_ext_s = m_ext_s >> 1;
        cen0     = (sum_s >= m_ext_s);
        cenb0    = (sum_s >= mh_ext_s) && !half_r;
        if (cen0) begin
            // acc < m and n <= m keep sum - m below m, so it fits WC+1 bits.
            acc_nxt_s  = (WC+1)'(sum_s - m_ext_s);
            half_nxt_s = 1'b0;
        end else if (cenb0) begin
            acc_nxt_s  = (WC+1)'(sum_s);
            half_nxt_s = 1'b1;
        end else begin
            acc_nxt_s  = (WC+1)'(sum_s);
            half_nxt_s = half_r;
        end
    end

    // Accumulator and half-phase state.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc_r  <= '0;
            half_r <= 1'b0;
        end else begin
            acc_r  <= acc_nxt_s;
            half_r <= half_nxt_s;
        end
    end

endmodule

// File: rtl/jtframe_frac_cen_gen.sv
// jtframe_frac_cen_gen
// Derives fractional clock-enable pulse trains from the system clock:
// cen[0] pulses n_act times every m_act clk cycles, cen[k] at 1/2^k of that,
// and cenb[] marks the half-period point. The ratio can be changed at run
// time through a load/ack/err handshake; the new ratio takes effect on the
// next cen0 boundary, and locked reports a settled ratio.
// Optional build macro JTFRAME_CEN_STALL_EN adds a stall input that holds
// off enables and replays the suppressed cen0 pulses afterwards as credit.
// Ports:
//   clk     system clock
//   rst     synchronous active-high reset
//   stall   (JTFRAME_CEN_STALL_EN only) suppress enables, bank credit
//   n, m    requested ratio
//   load    one-cycle request to adopt n/m
//   ack     pulse: request accepted
//   err     pulse: request rejected
//   cen     clock-enable pulses
//   cenb    half-period-shifted enable pulses
//   locked  ratio stable
module jtframe_frac_cen_gen
    import jtframe_cen_pkg::*;
#(
    parameter int W     = 2,
    parameter int WC    = CEN_WC,
    parameter int N_RST = 1,
    parameter int M_RST = 8
)(
    input  logic          clk,
    input  logic          rst,
`ifdef JTFRAME_CEN_STALL_EN
    input  logic          stall,
`endif
    input  logic [WC-1:0] n,
    input  logic [WC-1:0] m,
    input  logic          load,
    output logic          ack,
    output logic          err,
    output logic [W-1:0]  cen,
    output logic [W-1:0]  cenb,
    output logic          locked
);

    localparam int DW = (W > 1) ? W - 1 : 1;

    logic [WC-1:0] n_act_r;
    logic [WC-1:0] m_act_r;
    logic [WC-1:0] n_sh_r;
    logic [WC-1:0] m_sh_r;
    logic          pend_r;
    logic [DW-1:0] div_r;
    logic          seen_r;
    logic          locked_r;
    logic          ack_r;
    logic          err_r;
    logic [W-1:0]  cen_r;
    logic [W-1:0]  cenb_r;

    logic          raw_cen0_s;
    logic          raw_cenb0_s;
    logic          eff_cen0_s;
    logic          eff_cenb0_s;
    logic          apply_s;
    logic          load_ok_s;
    logic [W-1:0]  ones_s;
    logic [W-1:0]  cen_nxt_s;
    logic [W-1:0]  cenb_nxt_s;

    jtframe_frac_acc #(.WC(WC)) u_acc (
        .clk   (clk),
        .rst   (rst),
        .n_act (n_act_r),
        .m_act (m_act_r),
        .clr   (apply_s),
        .cen0  (raw_cen0_s),
        .cenb0 (raw_cenb0_s)
    );

    assign load_ok_s = ratio_valid(32'(n), 32'(m));
    // Ratio changes land on a period boundary so no partial period is emitted.
    assign apply_s   = pend_r && (raw_cen0_s || (n_act_r == '0));

`ifdef JTFRAME_CEN_STALL_EN
    logic [CREDIT_W-1:0] credit_r;
    logic [CREDIT_W-1:0] credit_nxt_s;

    // Stall gating: bank suppressed pulses, replay them in idle cycles.
    always_comb begin
        eff_cen0_s   = raw_cen0_s;
        eff_cenb0_s  = raw_cenb0_s;
        credit_nxt_s = credit_r;
        if (stall) begin
            eff_cen0_s  = 1'b0;
            eff_cenb0_s = 1'b0;
            if (raw_cen0_s && (credit_r != CREDIT_MAX)) begin
                credit_nxt_s = credit_r + 4'd1;
            end else begin
                credit_nxt_s = credit_r;
            end
        end else if (!raw_cen0_s && (credit_r != 4'd0)) begin
            eff_cen0_s   = 1'b1;
            credit_nxt_s = credit_r - 4'd1;
        end else begin
            credit_nxt_s = credit_r;
        end
    end

    // Credit counter, restarted with every new ratio.
    always_ff @(posedge clk) begin
        if (rst || apply_s) begin
            credit_r <= '0;
        end else begin
            credit_r <= credit_nxt_s;
        end
    end
`else
    // Without stall support the raw enables pass straight through.
    always_comb begin
        eff_cen0_s  = raw_cen0_s;
        eff_cenb0_s = raw_cenb0_s;
    end
`endif

    // Divided enables: output k fires when the low k divider bits are all ones.
    always_comb begin
        ones_s     = '0;
        cen_nxt_s  = '0;
        cenb_nxt_s = '0;
        ones_s[0]  = 1'b1;
        for (int k = 1; k < W; k++) begin
            ones_s[k] = ones_s[k-1] & div_r[k-1];
        end
        for (int k = 0; k < W; k++) begin
            cen_nxt_s[k]  = eff_cen0_s  & ones_s[k];
            cenb_nxt_s[k] = eff_cenb0_s & ones_s[k];
        end
    end

    // Active ratio, shadow register and pending flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_act_r <= WC'(N_RST);
            m_act_r <= WC'(M_RST);
            n_sh_r  <= '0;
            m_sh_r  <= '0;
            pend_r  <= 1'b0;
        end else begin
            if (apply_s) begin
                n_act_r <= n_sh_r;
                m_act_r <= m_sh_r;
            end
            // A fresh request wins over a simultaneous apply of the old shadow.
            if (load && load_ok_s) begin
                n_sh_r <= n;
                m_sh_r <= m;
                pend_r <= 1'b1;
            end else if (apply_s) begin
                pend_r <= 1'b0;
            end
        end
    end

    // Divider for the slower enable outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r <= '0;
        end else if (eff_cen0_s) begin
            div_r <= div_r + 1'b1;
        end
    end

    // Lock tracking: locked after the second natural wrap with a stable ratio.
    always_ff @(posedge clk) begin
        if (rst || apply_s) begin
            seen_r   <= 1'b0;
            locked_r <= 1'b0;
        end else if (raw_cen0_s) begin
            seen_r <= 1'b1;
            if (seen_r) begin
                locked_r <= 1'b1;
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cen_r  <= '0;
            cenb_r <= '0;
            ack_r  <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            cen_r  <= cen_nxt_s;
            cenb_r <= cenb_nxt_s;
            ack_r  <= load && load_ok_s;
            err_r  <= load && !load_ok_s;
        end
    end

    assign cen    = cen_r;
    assign cenb   = cenb_r;
    assign ack    = ack_r;
    assign err    = err_r;
    assign locked = locked_r;

endmodule

// File: tb/tb_jtframe_frac_cen_gen.sv
`timescale 1ns/1ps
module tb_jtframe_frac_cen_gen;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       load = 1'b0;
    logic [9:0] n    = 10'd0;
    logic [9:0] m    = 10'd0;
    logic       ack;
    logic       err;
    logic       locked;
    logic [1:0] cen;
    logic [1:0] cenb;
`ifdef JTFRAME_CEN_STALL_EN
    logic       stall = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    int t     = 0;

    always #5 clk = ~clk;

    jtframe_frac_cen_gen #(.W(2), .WC(10), .N_RST(1), .M_RST(8)) dut (
        .clk    (clk),
        .rst    (rst),
`ifdef JTFRAME_CEN_STALL_EN
        .stall  (stall),
`endif
        .n      (n),
        .m      (m),
        .load   (load),
        .ack    (ack),
        .err    (err),
        .cen    (cen),
        .cenb   (cenb),
        .locked (locked)
    );

    task automatic tick;
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cen(input int limit, output int waited);
        waited = -1;
        for (int k = 1; k <= limit; k++) begin
            tick;
            if (cen[0]) begin
                waited = k;
                break;
            end
        end
    endtask

    initial begin
        logic [4:0] e5;
        logic [1:0] e2;
        int waited;
        int cnt;

        // Reset state
        rst = 1'b1;
        tick;
        tick;
        chk("reset_out", 32'({cen, cenb, ack, err, locked}), 32'd0);
        rst = 1'b0;
        t = 0;

        // Default 1/8: cen[0] every 8, cen[1] every 16, cenb[0] 4 after cen[0]
        for (int i = 1; i <= 32; i++) begin
            tick;
            e5 = {(i % 16 == 0), (i % 8 == 0), (i % 16 == 12), (i % 8 == 4), (i >= 16)};
            chk("base_pattern", 32'({cen, cenb, locked}), 32'(e5));
        end

        // Rejected loads: err only, ratio and lock untouched
        load = 1'b1; n = 10'd9; m = 10'd8;
        tick;
        chk("reject_n_gt_m", 32'({ack, err}), 32'd1);
        n = 10'd1; m = 10'd0;
        tick;
        chk("reject_m0", 32'({ack, err}), 32'd1);
        n = 10'd0; m = 10'd8;
        tick;
        chk("reject_n0", 32'({ack, err}), 32'd1);
        load = 1'b0;
        while (t < 64) begin
            tick;
            e5 = {1'b0, 1'b0, (t % 8 == 0), 1'b1, 1'b0};
            chk("after_reject", 32'({ack, err, cen[0], locked, 1'b0}), 32'(e5));
        end

        // Two loads while pending: last shadow (5/5) wins, two acks
        load = 1'b1; n = 10'd2; m = 10'd7;
        tick;
        chk("ack_first", 32'({ack, err}), 32'd2);
        n = 10'd5; m = 10'd5;
        tick;
        chk("ack_second", 32'({ack, err}), 32'd2);
        load = 1'b0;
        wait_cen(20, waited);
        chk("apply_wait", 32'(waited), 32'd6);
        chk("apply_unlock", 32'(locked), 32'd0);
        for (int j = 1; j <= 8; j++) begin
            tick;
            e2 = {1'b1, 1'b1};
            chk("n_eq_m", 32'({cen[0], cenb[0], locked}), 32'({e2, (j >= 2)}));
        end

        // Load 3/8: applies on the very next cycle since 5/5 wraps every cycle
        load = 1'b1; n = 10'd3; m = 10'd8;
        tick;
        chk("ack_3_8", 32'({ack, err}), 32'd2);
        load = 1'b0;
        tick;
        chk("apply_3_8", 32'({cen[0], locked}), 32'd2);
        for (int j = 1; j <= 16; j++) begin
            tick;
            e2 = {(j % 8 == 3) || (j % 8 == 6) || (j % 8 == 0), (j >= 6)};
            chk("ratio_3_8", 32'({cen[0], locked}), 32'(e2));
        end
        cnt = 0;
        for (int j = 0; j < 1000; j++) begin
            tick;
            if (cen[0]) cnt++;
        end
        chk("count_1000", 32'(cnt), 32'd375);

        // Reset with a pending request drops it
        load = 1'b1; n = 10'd5; m = 10'd5;
        tick;
        chk("ack_before_rst", 32'({ack, err}), 32'd2);
        load = 1'b0;
        rst = 1'b1;
        tick;
        chk("rst_pend_out", 32'({cen, cenb, ack, err, locked}), 32'd0);
        tick;
        rst = 1'b0;
        t = 0;
        for (int i = 1; i <= 24; i++) begin
            tick;
            e2 = {(i % 8 == 0), (i >= 16)};
            chk("post_rst_1_8", 32'({cen[0], locked}), 32'(e2));
        end

`ifdef JTFRAME_CEN_STALL_EN
        // Ratio 1/4, stall 40 cycles, then credit replay
        load = 1'b1; n = 10'd1; m = 10'd4;
        tick;
        chk("ack_1_4", 32'({ack, err}), 32'd2);
        load = 1'b0;
        wait_cen(20, waited);
        chk("apply_1_4_wait", 32'(waited), 32'd7);
        stall = 1'b1;
        cnt = 0;
        for (int j = 0; j < 40; j++) begin
            tick;
            if (cen[0] || cenb[0]) cnt++;
        end
        chk("stall_quiet", 32'(cnt), 32'd0);
        chk("credit_10", 32'(dut.credit_r), 32'd10);
        stall = 1'b0;
        cnt = 0;
        for (int j = 0; j < 80; j++) begin
            tick;
            if (cen[0]) cnt++;
        end
        chk("stall_replay", 32'(cnt), 32'd30);
        chk("credit_empty", 32'(dut.credit_r), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
